// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: tracks in-flight register usage,
// drives pipeline-register enables/flush/bubble, EX forwarding selects and a load-use stall counter.
module pipeline_hazard_ctrl #(
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_Rn,
    input  logic [4:0]       id_Rm,
    input  logic [4:0]       id_Rd,
    input  logic             id_usesRn,
    input  logic             id_usesRm,
    input  logic             id_RegWrite,
    input  logic             id_MemRead,
    input  logic             br_taken,
    input  logic             mem_busy,
    output logic             pc_wr_en,
    output logic             ifid_wr_en,
    output logic             ifid_flush,
    output logic             idex_wr_en,
    output logic             exmem_wr_en,
    output logic             memwb_wr_en,
    output logic             idex_bubble,
    output logic [1:0]       fwdA,
    output logic [1:0]       fwdB,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [4:0] ZR = 5'(ZERO_REG);

    typedef struct packed {
        logic       valid;
        logic [4:0] rn;
        logic [4:0] rm;
        logic [4:0] rd;
        logic       uses_rn;
        logic       uses_rm;
        logic       reg_write;
        logic       mem_read;
    } ex_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
    } mem_t;

    // WB only ever supplies forwarded data, so its MemRead bit has no consumer.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
    } wb_t;

    ex_t              ex_q, ex_d;
    mem_t             mem_q, mem_d;
    wb_t              wb_q, wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             lu;

    function automatic logic [1:0] fwd_sel(input logic ex_valid, input logic used,
                                           input logic [4:0] r, input mem_t m, input wb_t w);
        logic mem_wr;
        logic wb_wr;
        mem_wr = m.valid && m.reg_write && (m.rd == r) && (r != ZR);
        wb_wr  = w.valid && w.reg_write && (w.rd == r) && (r != ZR);
        fwd_sel = 2'b00;
        if (ex_valid && used) begin
            if (mem_wr && !m.mem_read) begin
                fwd_sel = 2'b10;
            end else if (wb_wr) begin
                fwd_sel = 2'b01;
            end
        end
    endfunction

    always_comb begin
        lu = id_valid && ex_q.valid && ex_q.mem_read && ex_q.reg_write && (ex_q.rd != ZR) &&
             ((id_usesRn && (id_Rn == ex_q.rd)) || (id_usesRm && (id_Rm == ex_q.rd)));

        pc_wr_en    = 1'b1;
        ifid_wr_en  = 1'b1;
        idex_wr_en  = 1'b1;
        exmem_wr_en = 1'b1;
        memwb_wr_en = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        stall_cnt_d = stall_cnt_q;

        // Priority: memory freeze, then branch squash, then load-use stall.
        if (mem_busy) begin
            pc_wr_en    = 1'b0;
            ifid_wr_en  = 1'b0;
            idex_wr_en  = 1'b0;
            exmem_wr_en = 1'b0;
            memwb_wr_en = 1'b0;
        end else if (br_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (lu) begin
            pc_wr_en    = 1'b0;
            ifid_wr_en  = 1'b0;
            idex_bubble = 1'b1;
            if (!(&stall_cnt_q)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end

        fwdA = fwd_sel(ex_q.valid, ex_q.uses_rn, ex_q.rn, mem_q, wb_q);
        fwdB = fwd_sel(ex_q.valid, ex_q.uses_rm, ex_q.rm, mem_q, wb_q);
    end

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!mem_busy) begin
            if (idex_bubble) begin
                ex_d = '0;
            end else begin
                ex_d = '{valid: id_valid, rn: id_Rn, rm: id_Rm, rd: id_Rd,
                         uses_rn: id_usesRn, uses_rm: id_usesRm,
                         reg_write: id_RegWrite, mem_read: id_MemRead};
            end
            mem_d = '{valid: ex_q.valid, rd: ex_q.rd,
                      reg_write: ex_q.reg_write, mem_read: ex_q.mem_read};
            wb_d  = '{valid: mem_q.valid, rd: mem_q.rd, reg_write: mem_q.reg_write};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, table-driven bench for pipeline_hazard_ctrl; a narrow-counter second instance
// shares the inputs so counter saturation is reachable in a few cycles.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_Rn, id_Rm, id_Rd;
    logic        id_usesRn, id_usesRm, id_RegWrite, id_MemRead;
    logic        br_taken, mem_busy;

    logic        pc_wr_en, ifid_wr_en, ifid_flush, idex_wr_en, exmem_wr_en, memwb_wr_en;
    logic        idex_bubble;
    logic [1:0]  fwdA, fwdB;
    logic [15:0] stall_cnt;

    logic        sm_pc_wr_en, sm_ifid_wr_en, sm_ifid_flush, sm_idex_wr_en;
    logic        sm_exmem_wr_en, sm_memwb_wr_en, sm_idex_bubble;
    logic [1:0]  sm_fwdA, sm_fwdB;
    logic [1:0]  sm_stall_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.ZERO_REG(31), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_Rn(id_Rn), .id_Rm(id_Rm), .id_Rd(id_Rd),
        .id_usesRn(id_usesRn), .id_usesRm(id_usesRm),
        .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead),
        .br_taken(br_taken), .mem_busy(mem_busy),
        .pc_wr_en(pc_wr_en), .ifid_wr_en(ifid_wr_en), .ifid_flush(ifid_flush),
        .idex_wr_en(idex_wr_en), .exmem_wr_en(exmem_wr_en), .memwb_wr_en(memwb_wr_en),
        .idex_bubble(idex_bubble), .fwdA(fwdA), .fwdB(fwdB), .stall_cnt(stall_cnt)
    );

    pipeline_hazard_ctrl #(.ZERO_REG(31), .CNT_W(2)) dut_sm (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_Rn(id_Rn), .id_Rm(id_Rm), .id_Rd(id_Rd),
        .id_usesRn(id_usesRn), .id_usesRm(id_usesRm),
        .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead),
        .br_taken(br_taken), .mem_busy(mem_busy),
        .pc_wr_en(sm_pc_wr_en), .ifid_wr_en(sm_ifid_wr_en), .ifid_flush(sm_ifid_flush),
        .idex_wr_en(sm_idex_wr_en), .exmem_wr_en(sm_exmem_wr_en), .memwb_wr_en(sm_memwb_wr_en),
        .idex_bubble(sm_idex_bubble), .fwdA(sm_fwdA), .fwdB(sm_fwdB), .stall_cnt(sm_stall_cnt)
    );

    typedef struct {
        logic        v;
        logic [4:0]  rn, rm, rd;
        logic        urn, urm, rw, mr, br, busy;
        logic [4:0]  en;
        logic        flush, bub;
        logic [1:0]  fa, fb;
        logic [15:0] cnt;
    } vec_t;

    localparam logic [4:0] EN_ALL = 5'b11111;
    localparam logic [4:0] EN_STL = 5'b00111;
    localparam logic [4:0] EN_FRZ = 5'b00000;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [4:0] rn, logic [4:0] rm, logic [4:0] rd,
                                logic urn, logic urm, logic rw, logic mr, logic br, logic busy,
                                logic [4:0] en, logic flush, logic bub,
                                logic [1:0] fa, logic [1:0] fb, logic [15:0] cnt);
        vec_t r;
        r.v = v; r.rn = rn; r.rm = rm; r.rd = rd;
        r.urn = urn; r.urm = urm; r.rw = rw; r.mr = mr; r.br = br; r.busy = busy;
        r.en = en; r.flush = flush; r.bub = bub; r.fa = fa; r.fb = fb; r.cnt = cnt;
        return r;
    endfunction

    task automatic driveId(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                           input logic [4:0] rd, input logic urn, input logic urm,
                           input logic rw, input logic mr, input logic br, input logic busy);
        id_valid = v; id_Rn = rn; id_Rm = rm; id_Rd = rd;
        id_usesRn = urn; id_usesRm = urm; id_RegWrite = rw; id_MemRead = mr;
        br_taken = br; mem_busy = busy;
    endtask

    task automatic applyStimulus(input vec_t t);
        driveId(t.v, t.rn, t.rm, t.rd, t.urn, t.urm, t.rw, t.mr, t.br, t.busy);
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] enVec();
        return {pc_wr_en, ifid_wr_en, idex_wr_en, exmem_wr_en, memwb_wr_en};
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Program walk: loads, forwarding chains, zero register, branch, freeze, back-to-back loads.
        //          v  rn  rm  rd  urn urm rw mr br bsy  en      fl bub fa     fb     cnt
        vecs.push_back(mk(1, 1,  0,  2,  1, 0, 1, 1, 0, 0, EN_ALL, 0, 0, 2'b00, 2'b00, 0));
        vecs.push_back(mk(1, 2,  4,  3,  1, 1, 1, 0, 0, 0, EN_STL, 0, 1, 2'b00, 2'b00, 0));
        vecs.push_back(mk(1, 2,  4,  3,  1, 1, 1, 0, 0, 0, EN_ALL, 0, 0, 2'b00, 2'b00, 1));
        vecs.push_back(mk(1, 6,  7,  5,  1, 1, 1, 0, 0, 0, EN_ALL, 0, 0, 2'b01, 2'b00, 1));
        vecs.push_back(mk(1, 8,  9,  5,  1, 1, 1, 0, 0, 0, EN_ALL, 0, 0, 2'b00, 2'b00, 1));
        vecs.push_back(mk(1, 5,  5,  5,  1, 1, 1, 0, 0, 0, EN_ALL, 0, 0, 2'b00, 2'b00, 1));
        vecs.push_back(mk(1, 11, 12, 31, 1, 1, 1, 0, 0, 0, EN_ALL, 0, 0, 2'b10, 2'b10, 1));
        vecs.push_back(mk(1, 5,  31, 13, 1, 1, 1, 0, 0, 0, EN_ALL, 0, 0, 2'b00, 2'b00, 1));
        vecs.push_back(mk(1, 1,  0,  31, 1, 0, 1, 1, 0, 0, EN_ALL, 0, 0, 2'b01, 2'b00, 1));
        vecs.push_back(mk(1, 31, 31, 14, 1, 1, 1, 0, 0, 0, EN_ALL, 0, 0, 2'b00, 2'b00, 1));
        vecs.push_back(mk(1, 1,  0,  2,  1, 0, 1, 1, 0, 0, EN_ALL, 0, 0, 2'b00, 2'b00, 1));
        vecs.push_back(mk(1, 4,  2,  3,  1, 1, 1, 0, 1, 0, EN_ALL, 1, 1, 2'b00, 2'b00, 1));
        vecs.push_back(mk(1, 4,  2,  3,  1, 1, 1, 0, 0, 0, EN_ALL, 0, 0, 2'b00, 2'b00, 1));
        vecs.push_back(mk(1, 1,  0,  6,  1, 0, 1, 1, 0, 0, EN_ALL, 0, 0, 2'b00, 2'b01, 1));
        vecs.push_back(mk(1, 6,  6,  7,  1, 1, 1, 0, 0, 1, EN_FRZ, 0, 0, 2'b00, 2'b00, 1));
        vecs.push_back(mk(1, 6,  6,  7,  1, 1, 1, 0, 0, 1, EN_FRZ, 0, 0, 2'b00, 2'b00, 1));
        vecs.push_back(mk(1, 6,  6,  7,  1, 1, 1, 0, 0, 1, EN_FRZ, 0, 0, 2'b00, 2'b00, 1));
        vecs.push_back(mk(1, 6,  6,  7,  1, 1, 1, 0, 0, 0, EN_STL, 0, 1, 2'b00, 2'b00, 1));
        vecs.push_back(mk(1, 6,  6,  7,  1, 1, 1, 0, 0, 0, EN_ALL, 0, 0, 2'b00, 2'b00, 2));
        vecs.push_back(mk(0, 0,  0,  0,  0, 0, 0, 0, 0, 0, EN_ALL, 0, 0, 2'b01, 2'b01, 2));
        vecs.push_back(mk(1, 1,  0,  8,  1, 0, 1, 1, 0, 0, EN_ALL, 0, 0, 2'b00, 2'b00, 2));
        vecs.push_back(mk(1, 8,  0,  9,  1, 0, 1, 1, 0, 0, EN_STL, 0, 1, 2'b00, 2'b00, 2));
        vecs.push_back(mk(1, 8,  0,  9,  1, 0, 1, 1, 0, 0, EN_ALL, 0, 0, 2'b00, 2'b00, 3));
        vecs.push_back(mk(1, 9,  0,  10, 1, 1, 1, 0, 0, 0, EN_STL, 0, 1, 2'b01, 2'b00, 3));
        vecs.push_back(mk(1, 9,  0,  10, 1, 1, 1, 0, 0, 0, EN_ALL, 0, 0, 2'b00, 2'b00, 4));
        vecs.push_back(mk(0, 0,  0,  0,  0, 0, 0, 0, 0, 0, EN_ALL, 0, 0, 2'b01, 2'b00, 4));
        vecs.push_back(mk(0, 0,  0,  0,  0, 0, 0, 0, 1, 1, EN_FRZ, 0, 0, 2'b00, 2'b00, 4));

        reset = 1'b1;
        driveId(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("reset_en", 16'(enVec()), 16'(EN_ALL));
        checkOutput("reset_flush", 16'(ifid_flush), 16'd0);
        checkOutput("reset_bubble", 16'(idex_bubble), 16'd0);
        checkOutput("reset_fwd", 16'({fwdA, fwdB}), 16'd0);
        checkOutput("reset_cnt", stall_cnt, 16'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("row%0d_en", i), 16'(enVec()), 16'(vecs[i].en));
            checkOutput($sformatf("row%0d_flush", i), 16'(ifid_flush), 16'(vecs[i].flush));
            checkOutput($sformatf("row%0d_bubble", i), 16'(idex_bubble), 16'(vecs[i].bub));
            checkOutput($sformatf("row%0d_fwdA", i), 16'(fwdA), 16'(vecs[i].fa));
            checkOutput($sformatf("row%0d_fwdB", i), 16'(fwdB), 16'(vecs[i].fb));
            checkOutput($sformatf("row%0d_cnt", i), stall_cnt, vecs[i].cnt);
        end

        // Asynchronous reset landing in the middle of a load-use stall cycle.
        @(negedge clk);
        driveId(1, 1, 0, 2, 1, 0, 1, 1, 0, 0);
        @(negedge clk);
        driveId(1, 2, 4, 3, 1, 1, 1, 0, 0, 0);
        #1;
        checkOutput("midstall_pc", 16'(pc_wr_en), 16'd0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_rst_en", 16'(enVec()), 16'(EN_ALL));
        checkOutput("async_rst_bubble", 16'(idex_bubble), 16'd0);
        checkOutput("async_rst_fwd", 16'({fwdA, fwdB}), 16'd0);
        checkOutput("async_rst_cnt", stall_cnt, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("post_rst_en", 16'(enVec()), 16'(EN_ALL));
        @(posedge clk);
        #1;
        checkOutput("post_rst_cnt", stall_cnt, 16'd0);

        // Repeated load-use stalls drive the 2-bit counter into saturation.
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            driveId(1, 1, 0, 2, 1, 0, 1, 1, 0, 0);
            @(negedge clk);
            driveId(1, 2, 4, 3, 1, 1, 1, 0, 0, 0);
            #1;
            checkOutput($sformatf("sat%0d_stall_pc", k), 16'(sm_pc_wr_en), 16'd0);
            @(posedge clk);
            #1;
            checkOutput($sformatf("sat%0d_cnt_small", k), 16'(sm_stall_cnt), 16'((k > 3) ? 3 : k));
            checkOutput($sformatf("sat%0d_cnt_wide", k), stall_cnt, 16'(k));
            @(negedge clk);
            driveId(1, 2, 4, 3, 1, 1, 1, 0, 0, 0);
            #1;
            checkOutput($sformatf("sat%0d_release_pc", k), 16'(sm_pc_wr_en), 16'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage pipeline. It keeps a shadow copy of each in-flight instruction's register usage and drives the write enables, flush and bubble controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also produces the EX-stage operand forwarding selects and counts load-use stall cycles.

## Interface
Parameters:
- ZERO_REG, 31: architectural zero register (X31/XZR); never tracked, never forwarded, never causes a hazard.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_Rn, id_Rm, id_Rd  in  5 each  ID-stage source and destination register numbers.
- id_usesRn, id_usesRm  in  1 each  ID instruction actually reads Rn / Rm.
- id_RegWrite, id_MemRead  in  1 each  ID instruction writes a register / is a load.
- br_taken  in  1  EX-stage branch resolved taken this cycle.
- mem_busy  in  1  data memory not ready; the whole pipeline freezes.
- pc_wr_en  out  1  PC register write enable.
- ifid_wr_en  out  1  IF/ID write enable.
- ifid_flush  out  1  load IF/ID with a NOP.
- idex_wr_en, exmem_wr_en, memwb_wr_en  out  1 each  stage register write enables.
- idex_bubble  out  1  load ID/EX control fields with zeros.
- fwdA, fwdB  out  2 each  EX operand select: 00 register file, 10 EX/MEM ALU result, 01 MEM/WB write-back data.
- stall_cnt  out  CNT_W  saturating count of load-use bubble cycles.

## Operation
- Shadow stages EX, MEM, WB. Each holds valid, Rd, RegWrite and MemRead. EX also holds Rn, Rm, usesRn, usesRm.
- "Writes r" means valid && RegWrite && Rd==r && r!=ZERO_REG.
- Load-use hazard (lu): id_valid && ex.valid && ex.MemRead && ex.RegWrite && ex.Rd!=ZERO_REG && ((id_usesRn && id_Rn==ex.Rd) || (id_usesRm && id_Rm==ex.Rd)).
- Control priority: mem_busy > br_taken > lu > normal.
  - freeze (mem_busy=1): all five write enables are 0. ifid_flush=0 and idex_bubble=0. Shadow state and stall_cnt are held.
  - flush (br_taken=1): all enables are 1, ifid_flush=1, idex_bubble=1. The PC loads the branch target. lu is ignored and not counted.
  - stall (lu=1): pc_wr_en=0, ifid_wr_en=0, idex_bubble=1. The other enables are 1. stall_cnt increments and saturates at all-ones.
  - normal: all enables are 1, ifid_flush=0, idex_bubble=0.
- Shadow update on posedge when not frozen:
  - EX gets ID fields, with valid=id_valid. If idex_bubble=1, EX gets all zeros instead.
  - MEM gets EX. WB gets MEM.
- Forwarding, computed separately for A (ex.Rn, ex.usesRn) and B (ex.Rm, ex.usesRm), only when ex.valid and the operand is used:
  - 10 if MEM writes the register and !MEM.MemRead.
  - else 01 if WB writes the register.
  - else 00.
  - MEM has priority over WB because it holds the newer value.
- A MEM-stage load whose Rd matches an EX operand cannot occur: lu has already inserted a bubble. In that case the select falls through to WB/regfile, with no special handling.

## Timing
- All enables, flush, bubble and fwd outputs are combinational from inputs and shadow state, valid within the same cycle.
- Shadow update and stall_cnt change on posedge clk.
- Load-use costs exactly 1 bubble cycle. The next cycle the dependent instruction sits in EX with the load in WB, and fwd=01 for that operand.
- A taken branch costs 2 squashed instructions (IF/ID and ID/EX).
- Reset (async, immediate): all shadow valid bits and fields = 0, stall_cnt = 0. With mem_busy=br_taken=id_valid=0, outputs are: all enables 1, ifid_flush=0, idex_bubble=0, fwdA=fwdB=00.
- Reset asserted mid-stall or mid-freeze clears state immediately. The first cycle after release behaves as normal.
- mem_busy asserted during an lu cycle: freeze wins. lu is re-evaluated each cycle after release, and counted once, in the cycle it takes effect.
- Back-to-back dependent loads each stall once.

## Test plan
- Reset: assert reset asynchronously between edges -> stall_cnt=0, fwdA=fwdB=00, all enables 1 immediately.
- Load-use: LDUR X2 in EX, ID ADD with Rn=2 (usesRn=1) -> pc_wr_en=0, ifid_wr_en=0, idex_bubble=1, stall_cnt 0->1. Next cycle: fwdA=01, no stall.
- Forward priority: MEM writes X5 (ALU), WB writes X5, EX reads Rn=5 and Rm=5 -> fwdA=10, fwdB=10. Then MEM Rd=31 -> fwdA=01 (from WB).
- Zero register: EX load with Rd=31, ID reads Rn=31 -> no stall, fwdA=00.
- Branch vs stall: br_taken=1 together with lu=1 -> ifid_flush=1, idex_bubble=1, pc_wr_en=1, stall_cnt unchanged. Next cycle EX valid=0.
- Freeze: mem_busy=1 for 3 cycles during lu -> all enables 0, shadow and stall_cnt held. On release, stall proceeds and stall_cnt increments once. Also preload stall_cnt to 0xFFFF, trigger lu -> stays 0xFFFF.
